// File: rtl/wb_posted_write_buffer.sv
// wb_posted_write_buffer
// Posted-write buffer between the management Wishbone port and the project
// harness. Upstream writes are acked in one cycle and queued; a downstream
// FSM replays them in order. Upstream reads wait until the queue has drained
// and the FSM is idle, which keeps program order.
//
// Optional feature macro: WB_BUF_TIMEOUT_EN
//   defined   - a 16-bit watchdog aborts downstream cycles lacking m_ack_i
//               after TIMEOUT cycles, sets sticky timeout_err_o; aborted reads
//               return 32'hDEAD_BEEF, aborted writes drop their entry.
//   undefined - no watchdog, timeout_err_o tied low, err_clr_i ignored.
//
// Ports:
//   wb_clk_i, reset_n           clock, async active-low reset
//   wbs_*                       upstream Wishbone slave (from the CPU)
//   m_*                         downstream Wishbone master (to the harness)
//   fifo_count_o                occupied write-queue entries
//   busy_o                      queue non-empty or downstream FSM not idle
//   err_clr_i, timeout_err_o    watchdog error clear / sticky flag
module wb_posted_write_buffer #(
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                   wb_clk_i,
   input  logic                   reset_n,
   input  logic                   wbs_cyc_i,
   input  logic                   wbs_stb_i,
   input  logic                   wbs_we_i,
   input  logic [3:0]             wbs_sel_i,
   input  logic [31:0]            wbs_adr_i,
   input  logic [31:0]            wbs_dat_i,
   output logic                   wbs_ack_o,
   output logic [31:0]            wbs_dat_o,
   output logic                   m_cyc_o,
   output logic                   m_stb_o,
   output logic                   m_we_o,
   output logic [3:0]             m_sel_o,
   output logic [31:0]            m_adr_o,
   output logic [31:0]            m_dat_o,
   input  logic                   m_ack_i,
   input  logic [31:0]            m_dat_i,
   output logic [$clog2(DEPTH):0] fifo_count_o,
   output logic                   busy_o,
   input  logic                   err_clr_i,
   output logic                   timeout_err_o
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [31:0] RD_ABORT_DATA = 32'hDEAD_BEEF;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } wr_entry_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      GAP  = 2'd3
   } state_t;

   wr_entry_t     mem [DEPTH];
   wr_entry_t     head;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   state_t        state;
   state_t        state_nxt;

   logic req;
   logic full;
   logic empty;
   logic push;
   logic pop;
   logic rd_done;
   logic tmo;

   assign head         = mem[rd_ptr];
   assign fifo_count_o = count;

   // Handshake decode and next-state logic
   always_comb begin
      req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
      full      = (count == CW'(DEPTH));
      empty     = (count == '0);
      pop       = (state == WR) & (m_ack_i | tmo);
      rd_done   = (state == RD) & (m_ack_i | tmo);
      // a pop in the same cycle frees the slot, so a full queue still accepts
      push      = req & wbs_we_i & (~full | pop);
      count_nxt = count;
      if (push & ~pop) begin
         count_nxt = count + CW'(1);
      end else if (pop & ~push) begin
         count_nxt = count - CW'(1);
      end
      state_nxt = state;
      case (state)
         IDLE: begin
            if (!empty) begin
               state_nxt = WR;
            end else if (req & ~wbs_we_i) begin
               state_nxt = RD;
            end
         end
         WR:      if (pop) state_nxt = GAP;
         RD:      if (rd_done) state_nxt = GAP;
         GAP:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Queue storage; contents are don't-care once pointers are reset
   always_ff @(posedge wb_clk_i) begin
      if (push) begin
         mem[wr_ptr] <= '{adr: wbs_adr_i, dat: wbs_dat_i, sel: wbs_sel_i};
      end
   end

   // State, pointers and registered outputs
   always_ff @(posedge wb_clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         busy_o    <= 1'b0;
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
         m_cyc_o   <= 1'b0;
         m_stb_o   <= 1'b0;
         m_we_o    <= 1'b0;
         m_sel_o   <= '0;
         m_adr_o   <= '0;
         m_dat_o   <= '0;
      end else begin
         state     <= state_nxt;
         count     <= count_nxt;
         busy_o    <= (count_nxt != '0) | (state_nxt != IDLE);
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);

         wbs_ack_o <= push | rd_done;
         wbs_dat_o <= '0;
         if (rd_done) begin
            wbs_dat_o <= m_ack_i ? m_dat_i : RD_ABORT_DATA;
         end

         m_cyc_o <= (state_nxt == WR) | (state_nxt == RD);
         m_stb_o <= (state_nxt == WR) | (state_nxt == RD);
         m_we_o  <= (state_nxt == WR);
         // address/data latched once on launch, held for the whole cycle
         if ((state == IDLE) && (state_nxt == WR)) begin
            m_adr_o <= head.adr;
            m_dat_o <= head.dat;
            m_sel_o <= head.sel;
         end else if ((state == IDLE) && (state_nxt == RD)) begin
            m_adr_o <= wbs_adr_i;
            m_dat_o <= '0;
            m_sel_o <= wbs_sel_i;
         end
      end
   end

`ifdef WB_BUF_TIMEOUT_EN
   localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

   logic [15:0] to_cnt;

   assign tmo = ((state == WR) | (state == RD)) & ~m_ack_i & (to_cnt == TO_LAST);

   // Watchdog: restarts on every state change, set beats clear
   always_ff @(posedge wb_clk_i or negedge reset_n) begin
      if (!reset_n) begin
         to_cnt        <= '0;
         timeout_err_o <= 1'b0;
      end else begin
         if (state_nxt != state) begin
            to_cnt <= '0;
         end else if ((state == WR) | (state == RD)) begin
            to_cnt <= to_cnt + 16'd1;
         end
         if (tmo) begin
            timeout_err_o <= 1'b1;
         end else if (err_clr_i) begin
            timeout_err_o <= 1'b0;
         end
      end
   end
`else
   logic unused_ok;

   assign tmo           = 1'b0;
   assign timeout_err_o = 1'b0;
   assign unused_ok     = err_clr_i & (TIMEOUT != 0);
`endif

endmodule
